// File: rtl/adc_captura_if.sv
// Signal bundle between the ADC capture block and its surroundings: the ADC serial pins,
// the capture enable and the sample handed to the filter stage.
interface adc_captura_if;
    logic        En;
    logic        Data_In;
    logic        Cs_n;
    logic        Sclk;
    logic [11:0] Data_Out;
    logic        Tx_Listo;
    logic        Frame_Err;

    modport master (
        input  En,
        input  Data_In,
        output Cs_n,
        output Sclk,
        output Data_Out,
        output Tx_Listo,
        output Frame_Err
    );

    modport slave (
        output En,
        output Data_In,
        input  Cs_n,
        input  Sclk,
        input  Data_Out,
        input  Tx_Listo,
        input  Frame_Err
    );
endinterface

// File: rtl/adc_captura.sv
// Serial ADC capture: runs one 16-SCLK frame per sample tick on a 12-bit AD7476-class ADC
// and hands each 12-bit sample to the next stage with a one-cycle strobe.
module adc_captura #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned SAMPLE_DIV = 1134
) (
    input logic          Clk,
    input logic          Rst,
    adc_captura_if.master bus
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SmpW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [SmpW-1:0] SmpLast = SmpW'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e          state_q, state_d;
    logic [SmpW-1:0] smp_cnt_q, smp_cnt_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [15:0]     shift_q, shift_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic [11:0]     data_q, data_d;
    logic            listo_q, listo_d;
    logic            ferr_q, ferr_d;
    logic            tick;

    assign tick = (smp_cnt_q == SmpLast);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= StIdle;
            smp_cnt_q <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            data_q    <= '0;
            listo_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            data_q    <= data_d;
            listo_q   <= listo_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        smp_cnt_d = tick ? '0 : smp_cnt_q + SmpW'(1);
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        data_d    = data_q;
        listo_d   = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                if (tick && bus.En) begin
                    state_d   = StConv;
                    cs_n_d    = 1'b0;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            StConv: begin
                if (bit_cnt_q == 5'd16) begin
                    state_d = StDone;
                    cs_n_d  = 1'b1;
                    sclk_d  = 1'b1;
                    data_d  = shift_q[11:0];
                    listo_d = 1'b1;
                    ferr_d  = |shift_q[15:12];
                end else if (div_cnt_q == DivLast) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    // Sample on the edge that raises SCLK; data was launched on the prior fall.
                    if (!sclk_q) begin
                        shift_d   = {shift_q[14:0], bus.Data_In};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.Cs_n      = cs_n_q;
    assign bus.Sclk      = sclk_q;
    assign bus.Data_Out  = data_q;
    assign bus.Tx_Listo  = listo_q;
    assign bus.Frame_Err = ferr_q;

endmodule

// File: tb/tb_adc_captura.sv
// Directed bench for adc_captura with CLK_DIV=2, SAMPLE_DIV=80 and a behavioural ADC that
// launches each frame bit on the falling SCLK edge.
module tb_adc_captura;

    logic clk;
    logic rst;
    adc_captura_if bus ();

    adc_captura #(
        .CLK_DIV   (2),
        .SAMPLE_DIV(80)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int edges = 0;
    int listo_count = 0;
    int ferr_stray = 0;
    logic [15:0] adc_word = '0;
    int adc_idx = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clk edges since reset release; a frame started by the tick after edge 79 has T0 at 80.
    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (bus.Tx_Listo) listo_count++;
        if (bus.Frame_Err && !bus.Tx_Listo) ferr_stray++;
    end

    always @(negedge bus.Cs_n) adc_idx = 15;

    always @(negedge bus.Sclk) begin
        if (adc_idx >= 0) begin
            bus.Data_In = adc_word[adc_idx];
            adc_idx--;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input logic [15:0] word, input int exp_t0,
                             input logic [11:0] exp_data, input logic exp_err,
                             input int drop_at, output int listo_at);
        int guard;
        int t0;
        int cs_low;
        int sclk_low;
        adc_word = word;
        listo_at = -1;
        guard = 0;
        while (bus.Cs_n && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("cs_fall", 32'(bus.Cs_n), 32'd0);
        if (bus.Cs_n) return;
        t0 = edges;
        check("t0", t0, exp_t0);
        cs_low = 0;
        sclk_low = 0;
        guard = 0;
        while (!bus.Tx_Listo && guard < 200) begin
            if (!bus.Cs_n) cs_low++;
            if (!bus.Sclk) sclk_low++;
            if (edges == drop_at) bus.En = 1'b0;
            @(negedge clk);
            guard++;
        end
        check("tx_listo", 32'(bus.Tx_Listo), 32'd1);
        check("latency", edges - t0, 32'd65);
        check("cs_low_cycles", cs_low, 32'd65);
        check("sclk_low_cycles", sclk_low, 32'd32);
        check("data_out", 32'(bus.Data_Out), 32'(exp_data));
        check("frame_err", 32'(bus.Frame_Err), 32'(exp_err));
        check("cs_done", 32'(bus.Cs_n), 32'd1);
        listo_at = edges;
        @(negedge clk);
        check("listo_pulse", 32'(bus.Tx_Listo), 32'd0);
        check("ferr_pulse", 32'(bus.Frame_Err), 32'd0);
        check("data_hold", 32'(bus.Data_Out), 32'(exp_data));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l1, l2, l3, l4, l5, l6;
        int cs_low;
        int sclk_low;
        int listo_before;
        int guard;

        rst = 1'b0;
        bus.En = 1'b0;
        bus.Data_In = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_cs_n", 32'(bus.Cs_n), 32'd1);
        check("rst_sclk", 32'(bus.Sclk), 32'd1);
        check("rst_data", 32'(bus.Data_Out), 32'd0);
        check("rst_listo", 32'(bus.Tx_Listo), 32'd0);
        check("rst_ferr", 32'(bus.Frame_Err), 32'd0);

        // Idle with En low: ticks at edges 79 and 159 must be ignored.
        rst = 1'b1;
        cs_low = 0;
        sclk_low = 0;
        repeat (200) begin
            @(negedge clk);
            if (!bus.Cs_n) cs_low++;
            if (!bus.Sclk) sclk_low++;
        end
        check("idle_cs_low", cs_low, 32'd0);
        check("idle_sclk_low", sclk_low, 32'd0);
        check("idle_listo", listo_count, 32'd0);
        check("idle_data", 32'(bus.Data_Out), 32'd0);

        bus.En = 1'b1;
        run_frame(16'h0A5C, 240, 12'hA5C, 1'b0, -1, l1);
        run_frame(16'h0FFF, 320, 12'hFFF, 1'b0, -1, l2);
        run_frame(16'h0001, 400, 12'h001, 1'b0, -1, l3);
        check("period_1", l2 - l1, 32'd80);
        check("period_2", l3 - l2, 32'd80);

        run_frame(16'h8123, 480, 12'h123, 1'b1, -1, l4);

        // En drops at T0+10; frame finishes, later ticks stay idle.
        run_frame(16'h0321, 560, 12'h321, 1'b0, 570, l5);
        listo_before = listo_count;
        cs_low = 0;
        while (edges < 800) begin
            @(negedge clk);
            if (!bus.Cs_n) cs_low++;
        end
        check("en_off_cs_low", cs_low, 32'd0);
        check("en_off_listo", listo_count - listo_before, 32'd0);

        // Reset in the middle of a frame.
        bus.En = 1'b1;
        adc_word = 16'h0777;
        guard = 0;
        while (bus.Cs_n && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("mid_t0", edges, 32'd880);
        while (edges < 900 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        listo_before = listo_count;
        rst = 1'b0;
        #1;
        check("arst_cs_n", 32'(bus.Cs_n), 32'd1);
        check("arst_sclk", 32'(bus.Sclk), 32'd1);
        check("arst_data", 32'(bus.Data_Out), 32'd0);
        check("arst_listo", 32'(bus.Tx_Listo), 32'd0);
        repeat (3) @(negedge clk);
        check("arst_no_listo", listo_count - listo_before, 32'd0);
        rst = 1'b1;
        run_frame(16'h0C3A, 80, 12'hC3A, 1'b0, -1, l6);

        check("stray_ferr", ferr_stray, 32'd0);
        check("listo_total", listo_count, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_captura.md
Name: adc_captura

Overview:
- Serial-to-parallel capture block for the audio path input side; it is the ADC counterpart of the DAC serializer.
- Drives chip-select and serial clock of a 12-bit serial ADC (AD7476-class frame: 4 leading zeros, then 12 data bits MSB first) at a fixed sample rate.
- Shifts the returned bits in and presents each 12-bit sample with a one-cycle Tx_Listo strobe to the filter/equalizer stage, which later feeds the DAC path.

Parameters:
- CLK_DIV, 4, Clk cycles per SCLK half-period (≥1).
- SAMPLE_DIV, 1134, Clk cycles per sample period (50 MHz / 44.1 kHz); must satisfy SAMPLE_DIV ≥ 34*CLK_DIV + 2.

Ports:
- Clk  input  1  system clock, all logic rising-edge.
- Rst  input  1  asynchronous, active-low reset.
- En  input  1  capture enable; sampled only in IDLE at a sample tick.
- Data_In  input  1  serial data from ADC (SDATA).
- Cs_n  output  1  ADC chip select, active low.
- Sclk  output  1  ADC serial clock; idles high.
- Data_Out  output  12  last captured sample, held until next frame completes.
- Tx_Listo  output  1  one-Clk pulse, Data_Out valid/new.
- Frame_Err  output  1  one-Clk pulse coincident with Tx_Listo when any leading bit ≠ 0.

Behaviour:
- Reset (Rst=0, async):
  - Cs_n=1, Sclk=1, Data_Out=0, Tx_Listo=0, Frame_Err=0.
  - Shift register=0, all counters=0, state=IDLE.
- Sample timer:
  - Free-running 0..SAMPLE_DIV-1, running regardless of En.
  - tick=1 on the cycle the count equals SAMPLE_DIV-1, then the count wraps to 0.
- States: IDLE, CONV, DONE.
- IDLE:
  - Cs_n=1, Sclk=1.
  - On tick with En=1: next cycle is T0, where Cs_n=0, state=CONV, and div/bit counters clear.
  - tick with En=0 is ignored.
- CONV:
  - div counter counts 0..CLK_DIV-1; at its terminal value Sclk toggles.
  - Falling edges of Sclk occur at T0+(2k-1)*CLK_DIV; rising edges occur at T0+2k*CLK_DIV, for k=1..16.
  - On the Clk edge that drives Sclk 0→1, Data_In is shifted into a 16-bit register (LSB-in, left shift), so bit 15 is the first bit received.
  - After the 16th rising edge (T0+32*CLK_DIV), state=DONE.
- DONE, one cycle, at T0+32*CLK_DIV+1:
  - Cs_n=1, Sclk=1.
  - Data_Out = shift[11:0] and Tx_Listo=1.
  - Frame_Err=1 if shift[15:12]≠0.
  - Next state is IDLE.
  - Data_Out is updated even on error.
- Latency: tick to Tx_Listo = 32*CLK_DIV+2 Clk cycles.
- Tx_Listo and Frame_Err are never high outside DONE.
- tick during CONV/DONE cannot occur under the parameter constraint. If a tick does arrive there, it is ignored, with no restart and no queueing.
- En deasserted mid-frame: the frame completes normally; no new frame starts.
- Reset mid-frame: the frame is aborted immediately to reset values; no Tx_Listo.
- Data_In is treated as synchronous to the generated Sclk. It is not double-synchronized, and the CLK_DIV≥1 setup margin is the ADC's responsibility.
- Sclk and Cs_n are registered outputs (glitch-free).

Test Plan (CLK_DIV=2, SAMPLE_DIV=80):
- Reset and idle: hold Rst=0 for 5 cycles, then release with En=0 for 200 cycles → Cs_n=1, Sclk=1, Data_Out=0, no Tx_Listo.
- Single frame: En=1; the ADC model shifts 16'h0A5C on Sclk falling edges → 16 Sclk pulses, each low for 2 Clk. Tx_Listo pulses at tick+66 with Data_Out=12'hA5C and Frame_Err=0; Cs_n is low for exactly 65 cycles.
- Back-to-back frames: send 16'h0FFF, then 16'h0001 → Tx_Listo pulses exactly 80 cycles apart, giving Data_Out=12'hFFF then 12'h001.
- Leading-bit error: send 16'h8123 → Data_Out=12'h123, with Frame_Err and Tx_Listo both high for the same single cycle.
- En drop mid-frame: deassert En at T0+10 → the current frame completes with correct data, and Cs_n stays high afterwards.
- Reset mid-frame: assert Rst at T0+20 → Cs_n=1 and Sclk=1 asynchronously, Data_Out=0, no Tx_Listo. After release with En=1, the next tick produces a correct frame.
